// File: rtl/nanov_pkg.sv
// Shared types and constants for the nanoV instruction fetch sequencer.
package nanov_pkg;

  // Fetch sequencer state; every state lasts a whole number of 32-clk slots.
  typedef enum logic [1:0] {
    ST_DESELECT = 2'd0,
    ST_CMD_ADDR = 2'd1,
    ST_FILL     = 2'd2,
    ST_RUN      = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [7:0]  SPI_READ_CMD = 8'h03;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // JAL and JALR share opcode[6:4]=110 and have opcode[2] set; the jump
  // decode only looks at those four bits.
  localparam logic [3:0] JUMP_SIG = {OPC_JAL[6:4], OPC_JALR[2]};

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  // Bit position of serial slot bit k in a little-endian word whose bytes
  // arrive MSB-first: 8*(k/8) + 7 - (k%8).
  function automatic logic [4:0] asm_index(input logic [4:0] k);
    return {k[4:3], ~k[2:0]};
  endfunction

endpackage

// File: rtl/nanov_instr_len.sv
// Number of 32-clk core cycles an instruction occupies (1 or 2).
module nanov_instr_len
  import nanov_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  ncyc
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_jump;
  logic       is_branch;
  logic       is_shift;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  // Jumps, conditional branches and shifts need a second core cycle.
  always_comb begin
    is_jump   = ({opcode[6:4], opcode[2]} == JUMP_SIG);
    is_branch = (opcode == OPC_BRANCH);
    is_shift  = ((opcode == OPC_OP) || (opcode == OPC_OP_IMM)) &&
                ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA));
    ncyc      = (is_jump || is_branch || is_shift) ? 2'd2 : 2'd1;
  end

endmodule

// File: rtl/nanov_fetch.sv
// SPI-flash instruction streamer feeding nanoV_core.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_DESELECT | cs_n high for one slot, restarts the flash read
//   ST_CMD_ADDR | shift out READ (0x03) and the 24-bit byte address
//   ST_FILL     | receive the first word of the new stream
//   ST_RUN      | core executes; next word streams in final cycle only
module nanov_fetch
  import nanov_pkg::*;
#(
  parameter int                 PC_BITS    = 22,
  parameter logic [PC_BITS-1:0] RESET_ADDR = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic        spi_clk_en,
  output logic        spi_mosi,
  input  logic        branch,
  input  logic        shift_pc,
  input  logic [31:0] data_out,
  output logic [31:0] instr,
  output logic [30:0] next_instr,
  output logic [2:0]  cycle,
  output logic [4:0]  counter,
  output logic        pc,
  output logic        running
);

  fetch_state_t       state, state_nxt;
  logic [4:0]         counter_q;
  logic [2:0]         cycle_q;
  logic [31:0]        instr_q;
  logic [31:0]        asm_q;
  logic [31:0]        asm_next;
  logic [PC_BITS-1:0] pc_q;
  logic [PC_BITS-1:0] pc_rot;
  logic               br_pend_q;
  logic [1:0]         ncyc;
  logic               slot_end;
  logic               final_cycle;
  logic               instr_end;
  logic               take_branch;
  logic               redirect;
  logic [31:0]        cmd_addr_word;
  logic               unused_data;

  nanov_instr_len u_instr_len (
    .instr (instr_q),
    .ncyc  (ncyc)
  );

  assign slot_end      = (counter_q == 5'd31);
  assign final_cycle   = (cycle_q == {1'b0, ncyc - 2'd1});
  assign instr_end     = (state == ST_RUN) && final_cycle && slot_end;
  assign take_branch   = br_pend_q || branch;
  assign redirect      = instr_end && take_branch;
  assign cmd_addr_word = {SPI_READ_CMD, 2'b00, pc_q};
  assign pc_rot        = shift_pc ? {pc_q[0], pc_q[PC_BITS-1:1]} : pc_q;
  assign unused_data   = ^{data_out[31:PC_BITS], data_out[1:0]};

  assign instr      = instr_q;
  assign next_instr = asm_q[30:0];
  assign cycle      = cycle_q;
  assign counter    = counter_q;
  assign pc         = (counter_q < 5'd22) ? pc_q[0] : 1'b0;

  // Partial word with this clk's miso bit merged in, so the word is whole
  // on the last bit of a slot.
  always_comb begin
    asm_next                      = asm_q;
    asm_next[asm_index(counter_q)] = spi_miso;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_DESELECT;
    else     state <= state_nxt;
  end

  // Slot-granular sequencing; RUN only leaves on a redirect.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_DESELECT: if (slot_end) state_nxt = ST_CMD_ADDR;
      ST_CMD_ADDR: if (slot_end) state_nxt = ST_FILL;
      ST_FILL:     if (slot_end) state_nxt = ST_RUN;
      ST_RUN:      if (redirect) state_nxt = ST_DESELECT;
      default:     state_nxt = ST_DESELECT;
    endcase
  end

  // SPI pin and status outputs decoded from state and slot position.
  always_comb begin
    spi_cs_n   = 1'b1;
    spi_clk_en = 1'b0;
    spi_mosi   = 1'b0;
    running    = 1'b0;
    case (state)
      ST_CMD_ADDR: begin
        spi_cs_n   = 1'b0;
        spi_clk_en = 1'b1;
        spi_mosi   = cmd_addr_word[~counter_q];
      end
      ST_FILL: begin
        spi_cs_n   = 1'b0;
        spi_clk_en = 1'b1;
      end
      ST_RUN: begin
        spi_cs_n   = 1'b0;
        spi_clk_en = final_cycle;
        running    = 1'b1;
      end
      default: ;
    endcase
  end

  // Slot counter, core cycle, word assembly, instruction and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= 5'd0;
      cycle_q   <= 3'd0;
      instr_q   <= NOP_INSTR;
      asm_q     <= 32'd0;
      pc_q      <= RESET_ADDR;
      br_pend_q <= 1'b0;
    end else begin
      counter_q <= counter_q + 5'd1;

      if (spi_clk_en) asm_q <= asm_next;

      if (redirect)       pc_q <= {data_out[PC_BITS-1:2], 2'b00};
      else if (instr_end) pc_q <= pc_rot + PC_BITS'(4);
      else                pc_q <= pc_rot;

      if (redirect)                      br_pend_q <= 1'b0;
      else if (state == ST_RUN && branch) br_pend_q <= 1'b1;

      if (state == ST_FILL && slot_end) begin
        instr_q <= asm_next;
      end else if (instr_end) begin
        // The prefetched word belongs to the fall-through path, so a
        // redirect drops it and the core sees NOP until the refill.
        instr_q <= take_branch ? NOP_INSTR : asm_next;
      end

      if (state == ST_RUN && slot_end)
        cycle_q <= final_cycle ? 3'd0 : cycle_q + 3'd1;
    end
  end

endmodule

// File: tb/tb_nanov_fetch.sv
// Self-checking bench for nanov_fetch with a small SPI flash model.
module tb_nanov_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_miso;
  logic        spi_cs_n;
  logic        spi_clk_en;
  logic        spi_mosi;
  logic        branch;
  logic        shift_pc;
  logic [31:0] data_out;
  logic [31:0] instr;
  logic [30:0] next_instr;
  logic [2:0]  cycle;
  logic [4:0]  counter;
  logic        pc;
  logic        running;

  int checks   = 0;
  int failures = 0;

  nanov_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .spi_miso   (spi_miso),
    .spi_cs_n   (spi_cs_n),
    .spi_clk_en (spi_clk_en),
    .spi_mosi   (spi_mosi),
    .branch     (branch),
    .shift_pc   (shift_pc),
    .data_out   (data_out),
    .instr      (instr),
    .next_instr (next_instr),
    .cycle      (cycle),
    .counter    (counter),
    .pc         (pc),
    .running    (running)
  );

  always #5 clk = ~clk;

  // Flash model: first 32 enabled edges after cs_n falls capture command
  // and address, then data bytes are returned MSB-first from that address.
  logic [7:0]  fmem [0:1023];
  int unsigned fbits = 0;
  logic [31:0] fcmd  = 32'd0;
  int unsigned fd;
  logic [9:0]  fa;

  always @(posedge clk) begin
    if (spi_cs_n) fbits <= 0;
    else if (spi_clk_en) begin
      if (fbits < 32) fcmd <= {fcmd[30:0], spi_mosi};
      fbits <= fbits + 1;
    end
  end

  always_comb begin
    fd       = 0;
    fa       = 10'd0;
    spi_miso = 1'b0;
    if (fbits >= 32) begin
      fd       = fbits - 32;
      fa       = fcmd[9:0] + 10'(fd / 8);
      spi_miso = fmem[fa][3'd7 - 3'(fd % 8)];
    end
  end

  task automatic put_word(input int a, input logic [31:0] w);
    fmem[a]   = w[7:0];
    fmem[a+1] = w[15:8];
    fmem[a+2] = w[23:16];
    fmem[a+3] = w[31:24];
  endtask

  function automatic logic [31:0] word_at(input logic [21:0] a);
    logic [9:0] b;
    b = a[9:0];
    return {fmem[b+10'd3], fmem[b+10'd2], fmem[b+10'd1], fmem[b]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [21:0] pc;
    logic [31:0] ins;
    int          ncyc;
    int          gap;
    bit          br;
    int          br_cyc;
    int          br_cnt;
    logic [31:0] target;
  } rec_t;

  rec_t tbl [11];

  function automatic rec_t mk(input logic [21:0] p, input logic [31:0] w, input int n,
                              input int g, input bit b, input int bc, input int bk,
                              input logic [31:0] t);
    rec_t r;
    r.pc = p; r.ins = w; r.ncyc = n; r.gap = g;
    r.br = b; r.br_cyc = bc; r.br_cnt = bk; r.target = t;
    return r;
  endfunction

  // Advance to the first clk of the instruction described by r, checking
  // the restart gap and what the flash was asked for.
  task automatic wait_start(input rec_t r);
    int n, cs_hi, bad;
    branch   = 1'b0;
    shift_pc = 1'b0;
    n = 0; cs_hi = 0; bad = 0;
    while (!(running === 1'b1 && counter === 5'd0 && cycle === 3'd0) && n < 400) begin
      if (spi_cs_n === 1'b1) cs_hi++;
      if (instr !== NOP || cycle !== 3'd0 || running !== 1'b0) bad++;
      @(negedge clk);
      n++;
    end
    check("gap", n, r.gap);
    if (r.gap != 0) begin
      check("cs_high_clks", cs_hi, 32);
      check("gap_nop", bad, 0);
      check("flash_cmd", fcmd, {8'h03, 2'b00, r.pc});
    end
  endtask

  // Play the core for one instruction: rotate the PC, optionally branch,
  // and check the per-clk sequencing outputs.
  task automatic run_instr(input rec_t r);
    logic [21:0] pcv;
    logic [31:0] nxt;
    int seq, zer;
    nxt = word_at(r.pc + 22'd4);
    seq = 0;
    check("instr", instr, r.ins);
    for (int c = 0; c < r.ncyc; c++) begin
      pcv = 22'd0;
      zer = 0;
      for (int k = 0; k < 32; k++) begin
        if (cycle !== 3'(c) || counter !== 5'(k) || running !== 1'b1 ||
            spi_cs_n !== 1'b0 || spi_mosi !== 1'b0 || instr !== r.ins ||
            spi_clk_en !== (c == r.ncyc - 1))
          seq++;
        if (k < 22) pcv[k] = pc;
        else if (pc !== 1'b0) zer++;
        if (c == r.ncyc - 1 && k == 24)
          check("next_instr_23_15", 32'(next_instr[23:15]), 32'(nxt[23:15]));
        shift_pc = (k < 22);
        branch   = r.br && (c == r.br_cyc) && (k == r.br_cnt);
        data_out = r.target;
        @(negedge clk);
      end
      check("pc_serial", 32'(pcv), 32'(r.pc));
      check("pc_zero_tail", zer, 0);
    end
    check("sequence", seq, 0);
  endtask

  initial begin
    rst      = 1'b1;
    branch   = 1'b0;
    shift_pc = 1'b0;
    data_out = 32'd0;

    for (int i = 0; i < 1024; i++) fmem[i] = 8'h00;
    put_word(32'h000, 32'h00500093);
    put_word(32'h004, 32'h00100113);
    put_word(32'h008, 32'h00200193);
    put_word(32'h00C, 32'h00209093);
    put_word(32'h010, 32'h00001537);
    put_word(32'h014, 32'h0EC0006F);
    put_word(32'h018, 32'h00400293);
    put_word(32'h100, 32'h00600313);
    put_word(32'h104, 32'h002081B3);
    put_word(32'h108, 32'h0020D0B3);
    put_word(32'h10C, 32'h000080E7);
    put_word(32'h110, 32'h00208463);
    put_word(32'h114, 32'h00A00513);
    put_word(32'h200, 32'h00900493);

    //               pc        word          ncyc gap br cyc cnt target
    tbl[0]  = mk(22'h000, 32'h00500093, 1, 96, 0, 0, 0,  32'h003FFFFC);
    tbl[1]  = mk(22'h004, 32'h00100113, 1, 0,  0, 0, 0,  32'h003FFFFC);
    tbl[2]  = mk(22'h008, 32'h00200193, 1, 0,  0, 0, 0,  32'h003FFFFC);
    tbl[3]  = mk(22'h00C, 32'h00209093, 2, 0,  0, 0, 0,  32'h003FFFFC);
    tbl[4]  = mk(22'h010, 32'h00001537, 1, 0,  0, 0, 0,  32'h003FFFFC);
    tbl[5]  = mk(22'h014, 32'h0EC0006F, 2, 0,  1, 0, 0,  32'h00000100);
    tbl[6]  = mk(22'h100, 32'h00600313, 1, 96, 0, 0, 0,  32'h003FFFFC);
    tbl[7]  = mk(22'h104, 32'h002081B3, 1, 0,  0, 0, 0,  32'h003FFFFC);
    tbl[8]  = mk(22'h108, 32'h0020D0B3, 2, 0,  0, 0, 0,  32'h003FFFFC);
    tbl[9]  = mk(22'h10C, 32'h000080E7, 2, 0,  0, 0, 0,  32'h003FFFFC);
    tbl[10] = mk(22'h110, 32'h00208463, 2, 0,  1, 1, 31, 32'hFFC00203);

    repeat (3) @(negedge clk);
    check("rst_cs_n",    32'(spi_cs_n),   32'd1);
    check("rst_clk_en",  32'(spi_clk_en), 32'd0);
    check("rst_mosi",    32'(spi_mosi),   32'd0);
    check("rst_instr",   instr,           NOP);
    check("rst_cycle",   32'(cycle),      32'd0);
    check("rst_counter", 32'(counter),    32'd0);
    check("rst_running", 32'(running),    32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      wait_start(tbl[i]);
      run_instr(tbl[i]);
    end

    // Redirect to 0x200 is underway; hit reset during its FILL slot.
    branch   = 1'b0;
    shift_pc = 1'b0;
    repeat (76) @(negedge clk);
    check("fill_before_rst", {26'd0, spi_cs_n, spi_clk_en, running, counter},
          {26'd0, 1'b0, 1'b1, 1'b0, 5'd12});
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cs_n",    32'(spi_cs_n),   32'd1);
    check("mid_rst_clk_en",  32'(spi_clk_en), 32'd0);
    check("mid_rst_mosi",    32'(spi_mosi),   32'd0);
    check("mid_rst_instr",   instr,           NOP);
    check("mid_rst_counter", 32'(counter),    32'd0);
    check("mid_rst_running", 32'(running),    32'd0);
    rst = 1'b0;

    wait_start(tbl[0]);
    run_instr(tbl[0]);
    wait_start(tbl[1]);
    run_instr(tbl[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
